// File: rtl/alu_pkg.sv
// Shared constants and enumerations for the ALU/memory operand sequencer.
package alu_pkg;

  localparam int DATA_W = 15;  // operand/result width, equal to the memory word
  localparam int ADDR_W = 4;   // memory address width
  localparam int DEPTH  = 8;   // valid entries; addresses >= DEPTH are illegal

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_NOT = 3'd5,
    OP_SHL = 3'd6,
    OP_SHR = 3'd7
  } opcode_t;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD_A = 3'd1,
    RD_B = 3'd2,
    EXEC = 3'd3,
    WB   = 3'd4
  } state_t;

endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU: eight operations mod 2^DATA_W plus a carry/borrow flag.
module alu_core import alu_pkg::*; #(
  parameter int DATA_W = alu_pkg::DATA_W
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  opcode_t           opcode,
  output logic [DATA_W-1:0] y,
  output logic              carry
);

  logic [DATA_W:0] ext;

  // Operation decode; the extra top bit of ext is the carry out / borrow.
  always_comb begin
    ext   = '0;
    y     = '0;
    carry = 1'b0;
    case (opcode)
      OP_ADD: begin
        ext   = {1'b0, a} + {1'b0, b};
        y     = ext[DATA_W-1:0];
        carry = ext[DATA_W];
      end
      OP_SUB: begin
        ext   = {1'b0, a} - {1'b0, b};
        y     = ext[DATA_W-1:0];
        carry = ext[DATA_W];  // set exactly when a < b
      end
      OP_AND: y = a & b;
      OP_OR:  y = a | b;
      OP_XOR: y = a ^ b;
      OP_NOT: y = ~a;
      OP_SHL: begin
        y     = {a[DATA_W-2:0], 1'b0};
        carry = a[DATA_W-1];
      end
      OP_SHR: begin
        y     = {1'b0, a[DATA_W-1:1]};
        carry = a[0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_mem_sequencer.sv
// Operand sequencer: reads A and B from the register memory, runs the ALU,
// and writes the result back. Sole master of the memory read/write ports.
module alu_mem_sequencer import alu_pkg::*; #(
  parameter int DATA_W = alu_pkg::DATA_W,
  parameter int ADDR_W = alu_pkg::ADDR_W,
  parameter int DEPTH  = alu_pkg::DEPTH
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [2:0]        opcode,
  input  logic [ADDR_W-1:0] src_a,
  input  logic [ADDR_W-1:0] src_b,
  input  logic [ADDR_W-1:0] dst,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] result,
  output logic              zero,
  output logic              carry,
  output logic [DATA_W-1:0] mem_data,
  output logic [ADDR_W-1:0] mem_w_addr,
  output logic [ADDR_W-1:0] mem_r_addr,
  output logic              mem_wen,
  output logic              mem_ren,
  input  logic [DATA_W-1:0] mem_q
);

  function automatic logic addr_bad(input logic [ADDR_W-1:0] a);
    return int'(a) >= DEPTH;
  endfunction

  state_t              state_q, state_d;
  opcode_t             op_q;
  logic [ADDR_W-1:0]   src_b_q, dst_q;
  logic [DATA_W-1:0]   op_a_q, result_q, mem_data_q;
  logic [ADDR_W-1:0]   mem_w_addr_q, mem_r_addr_q;
  logic                done_q, err_q, zero_q, carry_q, mem_wen_q, mem_ren_q;
  logic                accept, bad;
  logic [DATA_W-1:0]   alu_y;
  logic                alu_c;

  assign accept = (state_q == IDLE) && start;
  assign bad    = addr_bad(src_a) || addr_bad(src_b) || addr_bad(dst);

  // Next-state: an illegal request never leaves IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && !bad) state_d = RD_A;
      RD_A:    state_d = RD_B;
      RD_B:    state_d = EXEC;
      EXEC:    state_d = WB;
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Request latch plus done/err; src_a lives in mem_r_addr_q during RD_A.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      op_q    <= OP_ADD;
      src_b_q <= '0;
      dst_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= (state_q == WB) || (accept && bad);
      if (accept) begin
        op_q    <= opcode_t'(opcode);
        src_b_q <= src_b;
        dst_q   <= dst;
        err_q   <= bad;
      end
    end
  end

  // Operand A capture and result/flag registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      op_a_q   <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
    end else begin
      if (state_q == RD_B) op_a_q <= mem_q;
      if (state_q == EXEC) begin
        result_q <= alu_y;
        zero_q   <= (alu_y == '0);
        carry_q  <= alu_c;
      end
    end
  end

  // Memory-side outputs are registered so start/addresses never reach them
  // combinationally; addresses and data hold when the port is idle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mem_ren_q    <= 1'b0;
      mem_wen_q    <= 1'b0;
      mem_r_addr_q <= '0;
      mem_w_addr_q <= '0;
      mem_data_q   <= '0;
    end else begin
      mem_ren_q <= (state_d == RD_A) || (state_d == RD_B);
      mem_wen_q <= (state_d == WB);
      if (state_q == IDLE && state_d == RD_A) mem_r_addr_q <= src_a;
      if (state_q == RD_A)                    mem_r_addr_q <= src_b_q;
      if (state_q == EXEC) begin
        mem_w_addr_q <= dst_q;
        mem_data_q   <= alu_y;
      end
    end
  end

  alu_core #(.DATA_W(DATA_W)) u_alu (
    .a      (op_a_q),
    .b      (mem_q),
    .opcode (op_q),
    .y      (alu_y),
    .carry  (alu_c)
  );

  assign busy       = (state_q != IDLE);
  assign done       = done_q;
  assign err        = err_q;
  assign result     = result_q;
  assign zero       = zero_q;
  assign carry      = carry_q;
  assign mem_data   = mem_data_q;
  assign mem_w_addr = mem_w_addr_q;
  assign mem_r_addr = mem_r_addr_q;
  assign mem_wen    = mem_wen_q;
  assign mem_ren    = mem_ren_q;

endmodule

// File: tb/tb_alu_mem_sequencer.sv
// Bench: sequencer wired to an 8-entry register memory preloaded with mem[i]=i.
module tb_alu_mem_sequencer;
  import alu_pkg::*;

  logic              clock = 1'b0, reset_n = 1'b0, start = 1'b0;
  logic [2:0]        opcode = 3'd0;
  logic [ADDR_W-1:0] src_a = '0, src_b = '0, dst = '0;
  logic              busy, done, err, zero, carry, mem_wen, mem_ren;
  logic [DATA_W-1:0] result, mem_data;
  logic [DATA_W-1:0] mem_q = '0;
  logic [ADDR_W-1:0] mem_w_addr, mem_r_addr;

  int vectors = 0;
  int errs    = 0;

  typedef struct packed {
    logic              err;
    logic [DATA_W-1:0] res;
    logic              z;
    logic              c;
  } exp_t;

  exp_t sb[$];
  exp_t last = '0;
  logic [DATA_W-1:0] mem [8] = '{15'd0, 15'd1, 15'd2, 15'd3, 15'd4, 15'd5, 15'd6, 15'd7};
  logic [DATA_W-1:0] mdl [8] = '{15'd0, 15'd1, 15'd2, 15'd3, 15'd4, 15'd5, 15'd6, 15'd7};

  always #5 clock = ~clock;

  alu_mem_sequencer dut (
    .clock(clock), .reset_n(reset_n), .start(start), .opcode(opcode),
    .src_a(src_a), .src_b(src_b), .dst(dst), .busy(busy), .done(done), .err(err),
    .result(result), .zero(zero), .carry(carry), .mem_data(mem_data),
    .mem_w_addr(mem_w_addr), .mem_r_addr(mem_r_addr), .mem_wen(mem_wen),
    .mem_ren(mem_ren), .mem_q(mem_q)
  );

  // Register memory: registered read port, read-before-write.
  always @(posedge clock) begin
    if (mem_ren) mem_q <= mem[mem_r_addr[2:0]];
    if (mem_wen) mem[mem_w_addr[2:0]] = mem_data;
  end

  // Reference arithmetic in plain integers.
  function automatic exp_t model(input logic [2:0] op, input logic [DATA_W-1:0] a, b);
    int M, ia, ib, r;
    exp_t e;
    M = 1 << DATA_W; ia = int'(a); ib = int'(b); r = 0;
    e = '0;
    case (op)
      3'd0: begin r = (ia + ib) % M; e.c = (ia + ib) >= M; end
      3'd1: begin r = (ia - ib + M) % M; e.c = ia < ib; end
      3'd2: r = int'(a & b);
      3'd3: r = int'(a | b);
      3'd4: r = int'(a ^ b);
      3'd5: r = M - 1 - ia;
      3'd6: begin r = (ia * 2) % M; e.c = ia >= M / 2; end
      default: begin r = ia / 2; e.c = (ia % 2) == 1; end
    endcase
    e.res = DATA_W'(r);
    e.z   = (r == 0);
    return e;
  endfunction

  task automatic push_op(input logic [2:0] op, input int a, b, d);
    exp_t e;
    e = model(op, mdl[a], mdl[b]);
    mdl[d] = e.res;
    last = e;
    sb.push_back(e);
  endtask

  task automatic push_bad();
    exp_t e;
    e = last; e.err = 1'b1;
    sb.push_back(e);
  endtask

  // Drive one start pulse; returns at the negedge of cycle 1.
  task automatic issue(input logic [2:0] op, input int a, b, d);
    @(negedge clock);
    start = 1'b1; opcode = op;
    src_a = ADDR_W'(a); src_b = ADDR_W'(b); dst = ADDR_W'(d);
    @(negedge clock);
    start = 1'b0;
  endtask

  // Push, issue, and wait (bounded) for done; returns in the done cycle.
  task automatic run(input logic [2:0] op, input int a, b, d, output bit ok);
    push_op(op, a, b, d);
    issue(op, a, b, d);
    ok = 1'b0;
    for (int i = 0; i < 12 && !ok; i++) begin
      if (done) ok = 1'b1;
      else @(negedge clock);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    vectors++;
    if ({busy, done, err, zero, carry, mem_wen, mem_ren} !== 7'b0) begin
      errs++; $display("FAIL reset_flags got %b want 0", {busy, done, err, zero, carry, mem_wen, mem_ren});
    end
    vectors++;
    if ({result, mem_data, mem_w_addr, mem_r_addr} !== '0) begin
      errs++; $display("FAIL reset_data got %h want 0", {result, mem_data, mem_w_addr, mem_r_addr});
    end
    reset_n = 1'b1;
  endtask

  task automatic test_add();
    exp_t e, got;
    push_op(OP_ADD, 3, 5, 7);
    issue(OP_ADD, 3, 5, 7);
    vectors++;  // cycle 1: RD_A
    if ({busy, mem_ren, mem_wen, mem_r_addr} !== {3'b110, 4'd3}) begin
      errs++; $display("FAIL add_c1 got %b want %b", {busy, mem_ren, mem_wen, mem_r_addr}, {3'b110, 4'd3});
    end
    @(negedge clock);
    vectors++;  // cycle 2: RD_B
    if ({busy, mem_ren, mem_wen, mem_r_addr} !== {3'b110, 4'd5}) begin
      errs++; $display("FAIL add_c2 got %b want %b", {busy, mem_ren, mem_wen, mem_r_addr}, {3'b110, 4'd5});
    end
    @(negedge clock);
    vectors++;  // cycle 3: EXEC
    if ({busy, mem_ren, mem_wen, done} !== 4'b1000) begin
      errs++; $display("FAIL add_c3 got %b want 1000", {busy, mem_ren, mem_wen, done});
    end
    @(negedge clock);
    vectors++;  // cycle 4: WB
    if ({busy, mem_wen, mem_ren, mem_w_addr, mem_data, result} !== {3'b110, 4'd7, 15'd8, 15'd8}) begin
      errs++; $display("FAIL add_c4 got %h want %h", {busy, mem_wen, mem_ren, mem_w_addr, mem_data, result},
                       {3'b110, 4'd7, 15'd8, 15'd8});
    end
    @(negedge clock);
    vectors++;  // cycle 5: done
    if ({done, busy} !== 2'b10) begin
      errs++; $display("FAIL add_c5 done/busy got %b want 10", {done, busy});
    end
    e = sb.pop_front(); got = {err, result, zero, carry};
    vectors++;
    if (got !== e) begin errs++; $display("FAIL add_result got %h want %h", got, e); end
    vectors++;
    if (mem[7] !== mdl[7]) begin errs++; $display("FAIL add_mem7 got %h want %h", mem[7], mdl[7]); end
  endtask

  task automatic test_sub_writeback();
    exp_t e, got; bit ok;
    run(OP_SUB, 2, 5, 0, ok);
    e = sb.pop_front(); got = {err, result, zero, carry};
    vectors++;
    if (!ok || got !== e || result !== 15'h7FFD) begin
      errs++; $display("FAIL sub_borrow got %h want %h done=%0b", got, e, ok);
    end
    run(OP_ADD, 0, 1, 6, ok);
    e = sb.pop_front(); got = {err, result, zero, carry};
    vectors++;
    if (!ok || got !== e || result !== 15'h7FFE) begin
      errs++; $display("FAIL sub_writeback got %h want %h done=%0b", got, e, ok);
    end
  endtask

  task automatic test_logic_shift();
    exp_t e, got; bit ok;
    logic [2:0] ops [6] = '{OP_XOR, OP_SHR, OP_NOT, OP_SHL, OP_AND, OP_OR};
    int sa [6] = '{6, 6, 4, 4, 0, 4};
    int sbb[6] = '{6, 0, 0, 0, 6, 1};
    int ds [6] = '{5, 4, 4, 3, 7, 3};
    for (int i = 0; i < 6; i++) begin
      run(ops[i], sa[i], sbb[i], ds[i], ok);
      e = sb.pop_front(); got = {err, result, zero, carry};
      vectors++;
      if (!ok || got !== e) begin
        errs++; $display("FAIL logic_op%0d got %h want %h done=%0b", i, got, e, ok);
      end
    end
  endtask

  task automatic test_illegal();
    exp_t e, got; bit ok;
    int bad_b [2] = '{9, 2};
    int bad_d [2] = '{2, 8};
    for (int k = 0; k < 2; k++) begin
      push_bad();
      issue(OP_ADD, 1, bad_b[k], bad_d[k]);
      vectors++;
      if ({done, err, busy, mem_ren, mem_wen} !== 5'b11000) begin
        errs++; $display("FAIL illegal%0d_c1 got %b want 11000", k, {done, err, busy, mem_ren, mem_wen});
      end
      e = sb.pop_front(); got = {err, result, zero, carry};
      vectors++;
      if (got !== e) begin errs++; $display("FAIL illegal%0d_hold got %h want %h", k, got, e); end
      for (int c = 2; c <= 4; c++) begin
        @(negedge clock);
        vectors++;
        if ({done, err, busy, mem_ren, mem_wen} !== 5'b01000) begin
          errs++; $display("FAIL illegal%0d_c%0d got %b want 01000", k, c, {done, err, busy, mem_ren, mem_wen});
        end
      end
    end
    run(OP_ADD, 1, 1, 5, ok);
    e = sb.pop_front(); got = {err, result, zero, carry};
    vectors++;
    if (!ok || got !== e) begin errs++; $display("FAIL illegal_clear got %h want %h done=%0b", got, e, ok); end
  endtask

  task automatic test_back_to_back();
    exp_t e, got;
    for (int i = 0; i <= 15; i++) begin
      @(negedge clock);
      vectors++;
      if (done !== (i == 5 || i == 10 || i == 15)) begin
        errs++; $display("FAIL b2b_done_c%0d got %b want %b", i, done, (i == 5 || i == 10 || i == 15));
      end
      if (done && sb.size() > 0) begin
        e = sb.pop_front(); got = {err, result, zero, carry};
        vectors++;
        if (got !== e) begin errs++; $display("FAIL b2b_result_c%0d got %h want %h", i, got, e); end
      end
      if (i == 6) begin
        vectors++;
        if ({mem_ren, mem_r_addr} !== {1'b1, 4'd5}) begin
          errs++; $display("FAIL b2b_raw_addr got %b want %b", {mem_ren, mem_r_addr}, {1'b1, 4'd5});
        end
      end
      if (i <= 10) begin
        start = 1'b1;
        case (i)
          0:  begin opcode = OP_ADD; src_a = 4'd1; src_b = 4'd2; dst = 4'd5; push_op(OP_ADD, 1, 2, 5); end
          5:  begin opcode = OP_ADD; src_a = 4'd5; src_b = 4'd5; dst = 4'd6; push_op(OP_ADD, 5, 5, 6); end
          10: begin opcode = OP_SUB; src_a = 4'd6; src_b = 4'd1; dst = 4'd7; push_op(OP_SUB, 6, 1, 7); end
          default: begin opcode = OP_OR; src_a = 4'd0; src_b = 4'd1; dst = 4'd2; end
        endcase
      end else start = 1'b0;
    end
    start = 1'b0;
  endtask

  task automatic test_reset_mid();
    exp_t e, got; bit ok; bit saw_wen;
    issue(OP_XOR, 0, 1, 4);
    @(negedge clock);  // cycle 2: RD_B
    reset_n = 1'b0;
    #1;
    vectors++;
    if ({busy, done, err, zero, carry, mem_wen, mem_ren, result, mem_data, mem_w_addr, mem_r_addr} !== '0) begin
      errs++; $display("FAIL midreset_outputs got %h want 0",
                       {busy, done, err, zero, carry, mem_wen, mem_ren, result, mem_data, mem_w_addr, mem_r_addr});
    end
    saw_wen = 1'b0;
    repeat (3) begin @(negedge clock); saw_wen |= mem_wen; end
    reset_n = 1'b1;
    repeat (3) begin @(negedge clock); saw_wen |= mem_wen; end
    vectors++;
    if (saw_wen !== 1'b0) begin errs++; $display("FAIL midreset_wen got 1 want 0"); end
    vectors++;
    if (mem[4] !== mdl[4]) begin errs++; $display("FAIL midreset_dst got %h want %h", mem[4], mdl[4]); end
    last = '0;
    run(OP_ADD, 1, 2, 7, ok);
    e = sb.pop_front(); got = {err, result, zero, carry};
    vectors++;
    if (!ok || got !== e || result !== 15'd3) begin
      errs++; $display("FAIL midreset_add got %h want %h done=%0b", got, e, ok);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired, vectors=%0d", vectors);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_add();
    test_sub_writeback();
    test_logic_shift();
    test_illegal();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
